// File: rtl/appliance_hub_if.sv
`default_nettype none
// ============================================================================
//  Module  : appliance_hub_if
//  Brief   : Command write port (valid/ready plus ack/err result pulses).
//  Revision: 1.0  initial release
// ============================================================================
interface appliance_hub_if #(
    parameter int VAL_W = 5
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_dev;
    logic [1:0]       cmd_field;
    logic [VAL_W-1:0] cmd_data;
    logic             cmd_ack;
    logic             cmd_err;

    modport master (
        output cmd_valid, cmd_dev, cmd_field, cmd_data,
        input  cmd_ready, cmd_ack, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_dev, cmd_field, cmd_data,
        output cmd_ready, cmd_ack, cmd_err
    );
endinterface
`default_nettype wire

// File: rtl/appliance_hub.sv
`default_nettype none
// ============================================================================
//  Module  : appliance_hub
//  Brief   : NUM_DEV appliance slots (setpoint/level/power/auto-off timer)
//            written one command at a time, timers driven by a shared tick.
//  Revision: 1.0  initial release
// ============================================================================
module appliance_hub #(
    parameter int NUM_DEV   = 4,
    parameter int VAL_W     = 5,
    parameter int TIME_W    = 8,
    parameter int SET_MIN   = 16,
    parameter int SET_MAX   = 30,
    parameter int LEVEL_MAX = 5
) (
    input  wire logic                      clk,
    input  wire logic                      rst_n,
    input  wire logic                      tick,
    appliance_hub_if.slave                 cmd,
    output logic [NUM_DEV*VAL_W-1:0]       dev_set,
    output logic [NUM_DEV*VAL_W-1:0]       dev_level,
    output logic [NUM_DEV*TIME_W-1:0]      dev_time,
    output logic [NUM_DEV-1:0]             dev_on,
    output logic [NUM_DEV-1:0]             dev_done
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_APPLY = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic              r_ready;
    logic              r_ack;
    logic              r_err;
    logic [3:0]        r_dev;
    logic [1:0]        r_field;
    logic [VAL_W-1:0]  r_data;
    logic              w_accept;
    logic              w_apply;
    logic              w_dev_ok;
    logic [VAL_W-1:0]  w_set_clamp;
    logic [VAL_W-1:0]  w_level_clamp;
    logic [TIME_W-1:0] w_time_load;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_apply     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept = cmd.cmd_valid && r_ready;
                if (w_accept) w_state_nxt = S_APPLY;
            end
            S_APPLY: begin
                w_apply     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dev   <= '0;
            r_field <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == S_IDLE);
            r_ack   <= w_apply && w_dev_ok;
            r_err   <= w_apply && !w_dev_ok;
            if (w_accept) begin
                r_dev   <= cmd.cmd_dev;
                r_field <= cmd.cmd_field;
                r_data  <= cmd.cmd_data;
            end
        end
    end

    assign cmd.cmd_ready = r_ready;
    assign cmd.cmd_ack   = r_ack;
    assign cmd.cmd_err   = r_err;

    assign w_dev_ok    = (32'(r_dev) < NUM_DEV);
    assign w_time_load = TIME_W'(r_data) << 2;

    always_comb begin
        w_set_clamp = r_data;
        if (32'(r_data) < SET_MIN)
            w_set_clamp = VAL_W'(SET_MIN);
        else if (32'(r_data) > SET_MAX)
            w_set_clamp = VAL_W'(SET_MAX);
        w_level_clamp = (32'(r_data) > LEVEL_MAX) ? VAL_W'(LEVEL_MAX) : r_data;
    end

    for (genvar gi = 0; gi < NUM_DEV; gi++) begin : g_slot
        logic [VAL_W-1:0]  r_set;
        logic [VAL_W-1:0]  r_level;
        logic [TIME_W-1:0] r_time;
        logic              r_on;
        logic              r_done;
        logic              w_hit;
        logic              w_own_time;

        assign w_hit      = w_apply && w_dev_ok && (32'(r_dev) == gi);
        // Timer and power writes own dev_time this cycle, so the tick is dropped.
        assign w_own_time = w_hit && r_field[1];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_set   <= VAL_W'(SET_MIN);
                r_level <= '0;
                r_time  <= '0;
                r_on    <= 1'b0;
                r_done  <= 1'b0;
            end else begin
                r_done <= 1'b0;
                if (w_hit) begin
                    case (r_field)
                        2'd0:    r_set   <= w_set_clamp;
                        2'd1:    r_level <= w_level_clamp;
                        2'd2:    r_time  <= w_time_load;
                        default: begin
                            r_on <= r_data[0];
                            if (!r_data[0]) r_time <= '0;
                        end
                    endcase
                end
                if (tick && !w_own_time && r_on && (r_time != '0)) begin
                    if (r_time == TIME_W'(1)) begin
                        r_time <= '0;
                        r_on   <= 1'b0;
                        r_done <= 1'b1;
                    end else begin
                        r_time <= r_time - TIME_W'(1);
                    end
                end
            end
        end

        assign dev_set[gi*VAL_W +: VAL_W]     = r_set;
        assign dev_level[gi*VAL_W +: VAL_W]   = r_level;
        assign dev_time[gi*TIME_W +: TIME_W]  = r_time;
        assign dev_on[gi]                     = r_on;
        assign dev_done[gi]                   = r_done;
    end

endmodule
`default_nettype wire

// File: tb/tb_appliance_hub.sv
`default_nettype none
// ============================================================================
//  Module  : tb_appliance_hub
//  Brief   : Directed plus randomized bench for appliance_hub against a
//            transaction-level reference model.
//  Revision: 1.0  initial release
// ============================================================================
module tb_appliance_hub;

    localparam int NUM_DEV = 4;
    localparam int VAL_W   = 5;
    localparam int TIME_W  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick = 1'b0;
    logic [NUM_DEV*VAL_W-1:0]  dev_set;
    logic [NUM_DEV*VAL_W-1:0]  dev_level;
    logic [NUM_DEV*TIME_W-1:0] dev_time;
    logic [NUM_DEV-1:0]        dev_on;
    logic [NUM_DEV-1:0]        dev_done;

    appliance_hub_if #(.VAL_W(VAL_W)) bus ();

    appliance_hub #(
        .NUM_DEV(NUM_DEV), .VAL_W(VAL_W), .TIME_W(TIME_W),
        .SET_MIN(16), .SET_MAX(30), .LEVEL_MAX(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .cmd(bus.slave),
        .dev_set(dev_set), .dev_level(dev_level), .dev_time(dev_time),
        .dev_on(dev_on), .dev_done(dev_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: one pending command at most, slot state as plain ints.
    int m_set[NUM_DEV], m_level[NUM_DEV], m_time[NUM_DEV];
    bit m_on[NUM_DEV], m_done[NUM_DEV];
    bit m_ready, m_ack, m_err, m_pend;
    int p_dev, p_field, p_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic void model_reset();
        for (int s = 0; s < NUM_DEV; s++) begin
            m_set[s] = 16; m_level[s] = 0; m_time[s] = 0; m_on[s] = 0; m_done[s] = 0;
        end
        m_ready = 1; m_ack = 0; m_err = 0; m_pend = 0;
    endfunction

    function automatic void model_edge(bit r, bit t, bit v, int d, int f, int x);
        int hit;
        bit owns;
        hit = -1; owns = 0;
        if (r) begin
            model_reset();
            return;
        end
        for (int s = 0; s < NUM_DEV; s++) m_done[s] = 0;
        m_ack = 0; m_err = 0;
        if (m_pend) begin
            m_pend = 0; m_ready = 1;
            if (p_dev < NUM_DEV) begin
                m_ack = 1; hit = p_dev; owns = (p_field >= 2);
                case (p_field)
                    0: m_set[p_dev] = (p_data < 16) ? 16 : ((p_data > 30) ? 30 : p_data);
                    1: m_level[p_dev] = (p_data > 5) ? 5 : p_data;
                    2: m_time[p_dev] = p_data * 4;
                    default: begin
                        m_on[p_dev] = p_data[0];
                        if (!p_data[0]) m_time[p_dev] = 0;
                    end
                endcase
            end else begin
                m_err = 1;
            end
        end else if (v && m_ready) begin
            m_pend = 1; m_ready = 0; p_dev = d; p_field = f; p_data = x;
        end
        if (t) begin
            for (int s = 0; s < NUM_DEV; s++) begin
                if (!(s == hit && owns) && m_on[s] && m_time[s] > 0) begin
                    m_time[s] = m_time[s] - 1;
                    if (m_time[s] == 0) begin
                        m_on[s] = 0; m_done[s] = 1;
                    end
                end
            end
        end
    endfunction

    task automatic compare_all();
        logic [NUM_DEV*VAL_W-1:0]  e_set, e_level;
        logic [NUM_DEV*TIME_W-1:0] e_time;
        logic [NUM_DEV-1:0]        e_on, e_done;
        for (int s = 0; s < NUM_DEV; s++) begin
            e_set[s*VAL_W +: VAL_W]    = m_set[s][VAL_W-1:0];
            e_level[s*VAL_W +: VAL_W]  = m_level[s][VAL_W-1:0];
            e_time[s*TIME_W +: TIME_W] = m_time[s][TIME_W-1:0];
            e_on[s]   = m_on[s];
            e_done[s] = m_done[s];
        end
        check("ready", 32'(bus.cmd_ready), 32'(m_ready));
        check("ack", 32'(bus.cmd_ack), 32'(m_ack));
        check("err", 32'(bus.cmd_err), 32'(m_err));
        check("dev_set", 32'(dev_set), 32'(e_set));
        check("dev_level", 32'(dev_level), 32'(e_level));
        check("dev_time", dev_time, e_time);
        check("dev_on", 32'(dev_on), 32'(e_on));
        check("dev_done", 32'(dev_done), 32'(e_done));
    endtask

    task automatic step(input bit r, input bit t, input bit v,
                        input int d, input int f, input int x);
        @(negedge clk);
        rst_n = ~r; tick = t;
        bus.cmd_valid = v; bus.cmd_dev = 4'(d); bus.cmd_field = 2'(f); bus.cmd_data = 5'(x);
        @(posedge clk);
        model_edge(r, t, v, d, f, x);
        #1;
        compare_all();
    endtask

    task automatic send(input int d, input int f, input int x);
        step(0, 0, 1, d, f, x);
        step(0, 0, 0, 0, 0, 0);
    endtask

    int acks;

    initial begin
        bus.cmd_valid = 0; bus.cmd_dev = 0; bus.cmd_field = 0; bus.cmd_data = 0;
        model_reset();
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("rst_set", 32'(dev_set), 32'({4{5'd16}}));
        check("rst_ready", 32'(bus.cmd_ready), 32'd1);

        // Setpoint writes with clamping
        send(2, 0, 22);
        check("set2_22_ack", 32'(bus.cmd_ack), 32'd1);
        check("set2_22", 32'(dev_set[14:10]), 32'd22);
        check("set_others", 32'(dev_set[9:0]), 32'({2{5'd16}}));
        send(2, 0, 31);
        check("set2_hi_clamp", 32'(dev_set[14:10]), 32'd30);
        send(2, 0, 3);
        check("set2_lo_clamp", 32'(dev_set[14:10]), 32'd16);
        check("set2_lo_noerr", 32'(bus.cmd_err), 32'd0);
        send(1, 1, 9);
        check("level_clamp", 32'(dev_level[9:5]), 32'd5);

        // Timed run to expiry on slot 1
        send(1, 3, 1);
        send(1, 2, 2);
        check("time1_load", 32'(dev_time[15:8]), 32'd8);
        for (int k = 0; k < 8; k++) step(0, 1, 0, 0, 0, 0);
        check("exp_on1", 32'(dev_on[1]), 32'd0);
        check("exp_done1", 32'(dev_done[1]), 32'd1);
        check("exp_time1", 32'(dev_time[15:8]), 32'd0);
        step(0, 0, 0, 0, 0, 0);
        check("done1_pulse", 32'(dev_done[1]), 32'd0);

        // Out-of-range slot, then valid held high through APPLY
        send(4, 0, 5);
        check("bad_dev_err", 32'(bus.cmd_err), 32'd1);
        check("bad_dev_set", 32'(dev_set), 32'({4{5'd16}}));
        acks = 0;
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 1, 0, 1, k + 1);
            acks += int'(bus.cmd_ack);
        end
        check("held_valid_acks", 32'(acks), 32'd2);
        step(0, 0, 0, 0, 0, 0);

        // Timer write colliding with an expiring tick on slot 0
        send(0, 3, 1);
        send(0, 2, 1);
        for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0, 0);
        check("slot0_t1", 32'(dev_time[7:0]), 32'd1);
        step(0, 0, 1, 0, 2, 1);
        step(0, 1, 0, 0, 0, 0);
        check("collide_time", 32'(dev_time[7:0]), 32'd4);
        check("collide_on", 32'(dev_on[0]), 32'd1);
        check("collide_done", 32'(dev_done[0]), 32'd0);

        // Two slots expiring on the same tick
        send(3, 3, 1);
        send(3, 2, 1);
        for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        check("dual_done", 32'(dev_done), 32'b1001);
        check("dual_off", 32'(dev_on), 32'b0000);

        // Power-off while timed
        send(2, 3, 1);
        send(2, 2, 5);
        check("time2_20", 32'(dev_time[23:16]), 32'd20);
        send(2, 3, 0);
        check("poff_time", 32'(dev_time[23:16]), 32'd0);
        check("poff_on", 32'(dev_on[2]), 32'd0);
        check("poff_done", 32'(dev_done), 32'd0);

        // Reset during APPLY discards the command
        send(2, 3, 1);
        step(0, 0, 1, 1, 0, 25);
        step(1, 0, 0, 0, 0, 0);
        check("rst_apply_ack", 32'(bus.cmd_ack), 32'd0);
        check("rst_apply_set", 32'(dev_set), 32'({4{5'd16}}));
        check("rst_apply_on", 32'(dev_on), 32'd0);

        // Randomized traffic
        for (int k = 0; k < 2000; k++) begin
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 1) == 1), $urandom_range(0, 5),
                 $urandom_range(0, 3), $urandom_range(0, 31));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/appliance_hub.md
# appliance_hub

Parametrised multi-channel appliance controller: NUM_DEV identical appliance slots, each holding a setpoint, a level (fan/capacity), a power flag and an auto-off countdown timer. Commands arrive over a single valid/ready write port and are applied to one slot at a time; a shared external tick decrements all running timers. It replaces the fixed two-of-each device selector tree and sits between the user-input decode logic and the per-appliance display/actuator outputs.

## Interface
- NUM_DEV, 4, number of appliance slots (2..16)
- VAL_W, 5, width of setpoint/level/command data
- TIME_W, 8, timer width; must be ≥ VAL_W+2
- SET_MIN, 16, lowest legal setpoint
- SET_MAX, 30, highest legal setpoint; also setpoint reset value is SET_MIN
- LEVEL_MAX, 5, highest legal level
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- tick  in  1  one-cycle timebase pulse (e.g. 1 minute)
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_dev  in  4  target slot index
- cmd_field  in  2  0 setpoint, 1 level, 2 timer, 3 power (data[0]=on)
- cmd_data  in  VAL_W  command value
- cmd_ack  out  1  one-cycle pulse: command applied
- cmd_err  out  1  one-cycle pulse: command rejected
- dev_set  out  NUM_DEV*VAL_W  setpoints, slot i at [i*VAL_W +: VAL_W]
- dev_level  out  NUM_DEV*VAL_W  levels, same packing
- dev_time  out  NUM_DEV*TIME_W  remaining ticks per slot
- dev_on  out  NUM_DEV  power flag per slot
- dev_done  out  NUM_DEV  one-cycle pulse when a slot's timer expires

## Operation
- Command FSM: IDLE (cmd_ready=1) → on cmd_valid&&cmd_ready latch dev/field/data, go APPLY (cmd_ready=0) → apply, pulse cmd_ack or cmd_err, return IDLE. Throughput one command per 2 cycles.
- cmd_dev ≥ NUM_DEV: cmd_err, no state change.
- Setpoint: clamped to [SET_MIN, SET_MAX]; clamping still acks (no err).
- Level: clamped to LEVEL_MAX.
- Timer: dev_time ← cmd_data << 2 (zero-extended to TIME_W). Writing 0 cancels a running countdown; slot stays on.
- Power: data[0]=1 turns slot on; data[0]=0 turns off and clears dev_time to 0. Setpoint/level retained.
- Per-slot state: OFF (dev_on=0), RUN (on, time=0, no countdown), TIMED (on, time>0). Timer write while OFF stores value without counting; power-on with time>0 enters TIMED.
- In TIMED, each tick decrements dev_time by 1. When tick arrives with time==1: time←0, dev_on←0, dev_done[i] pulses for exactly one cycle. Multiple slots may expire in the same cycle.
- Ticks have no effect in OFF or RUN.

## Timing
- Reset (rst_n low at a clock edge): cmd_ready=1, cmd_ack=0, cmd_err=0, all dev_set=SET_MIN, dev_level=0, dev_time=0, dev_on=0, dev_done=0, FSM=IDLE. Reset mid-APPLY discards the pending command (no ack).
- Command latency: cmd_valid accepted at edge N; register/output update and cmd_ack/cmd_err visible after edge N+1; cmd_ready high again after edge N+1.
- Expiry latency: tick sampled at edge N with time==1 → dev_time=0, dev_on=0, dev_done=1 after edge N; dev_done=0 after edge N+1.
- Same-cycle command apply and tick on same slot: command wins for the written field; a timer/power write overrides the decrement, and no dev_done is generated by that tick. Tick still applies to all other slots.
- Outputs are registered; no combinational path from inputs to outputs except none (cmd_ready is registered).

## Test plan
- Reset, then setpoint write dev=2 data=22 → cmd_ack after 2 cycles, dev_set slot2=22, others=16; data=31 → clamped 30; data=3 → 16.
- Power on slot1, timer data=2 → dev_time=8; 8 ticks → after 8th tick dev_on[1]=0, dev_done[1] one-cycle pulse, dev_time=0.
- cmd_dev=NUM_DEV (4) → cmd_err pulse, no outputs change; cmd_valid held across APPLY is accepted only once per IDLE cycle.
- Timer write data=1 to slot0 in the same cycle as tick with slot0 time=1 → dev_time=4, dev_on stays 1, no dev_done.
- Slots 0 and 3 both TIMED at time=1, single tick → both dev_done bits pulse same cycle, both off.
- Power-off while TIMED (time=20) → dev_time=0, dev_on=0, no dev_done; assert rst_n low during APPLY → no ack, all outputs at reset values.
